mem_access_controller: RTL and testbench
========================================

Name: mem_access_controller

Overview:
Sequencer for the MEM-stage data-memory access in the MIPS pipeline. Accepts one load/store request from the pipeline and checks type and alignment. It drives a word-addressed data memory with byte enables and waits for a ready handshake, bounded by a timeout. For loads it aligns and sign/zero-extends the returned data. It stalls the pipeline until the access completes and reports faults.

Parameters:
ADDR_WIDTH, 10, word-address width presented to data memory (o_mem_addr = i_addr[ADDR_WIDTH+1:2])
TIMEOUT, 16, max ACCESS cycles without i_mem_ready before abort; legal range 1..255

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_req  in  1  access request; pipeline holds it and all request fields stable until o_done
i_we  in  1  1 = store, 0 = load
i_type  in  3  load/store type (encoding below)
i_addr  in  32  byte address
i_wdata  in  32  store data, right-justified
o_stall  out  1  pipeline stall = i_req & ~o_done (combinational)
o_done  out  1  one-cycle completion pulse
o_rdata  out  32  extended load result; valid with o_done, held until next o_done
o_fault  out  2  00 ok, 01 misaligned, 10 invalid type, 11 timeout; valid with o_done, else 00
o_mem_en  out  1  memory access strobe
o_mem_we  out  4  byte write enables, bit n = byte lane n
o_mem_addr  out  ADDR_WIDTH  word address
o_mem_wdata  out  32  lane-replicated store data
i_mem_rdata  in  32  memory read word, valid when i_mem_ready
i_mem_ready  in  1  memory completes access this cycle

Behaviour:
- Type encoding (loads): 000 byte signed, 001 half signed, 011 word, 100 byte unsigned, 101 half unsigned, 111 word. 010 and 110 are invalid.
- Stores use i_type[1:0]: 00 byte, 01 half, 11 word. 10 is invalid; i_type[2] is ignored.
- Misaligned: a half access with addr[0]=1, or a word access with addr[1:0]!=00. The invalid-type check takes priority over the misaligned check.
- FSM states are IDLE, ACCESS and DONE.
- IDLE, i_req=1: register we, type, addr and wdata.
  - Fault detected: go to DONE with the fault code; no memory access is made.
  - No fault: go to ACCESS and clear the timeout counter.
- ACCESS: o_mem_en=1; o_mem_addr, o_mem_we and o_mem_wdata come from registered fields and stay stable.
  - i_mem_ready=1: capture the load result, go to DONE.
  - Counter reaches TIMEOUT-1 with no ready: go to DONE with fault 11; o_rdata is set to 0.
  - Ready wins if it coincides with the timeout.
- DONE: o_done=1 for exactly one cycle, then IDLE. i_req seen during DONE is the completing request and is not re-accepted. A new request can be accepted in the cycle after DONE.
- Latency: request seen in cycle 0 with ready in cycle 1 gives o_done in cycle 2. A fault path gives o_done in cycle 1.
- Byte enables and store data, with off = addr[1:0]:
  - Byte: o_mem_we = 0001<<off, o_mem_wdata = {4{wdata[7:0]}}.
  - Half: o_mem_we = 0011<<off, o_mem_wdata = {2{wdata[15:0]}}.
  - Word: o_mem_we = 1111, o_mem_wdata = wdata.
  - Loads: o_mem_we = 0000.
- Load data: shift i_mem_rdata right by 8*off, then sign- or zero-extend per type from bit 7, bit 15, or none (word). Register the result into o_rdata.
- Stores leave o_rdata unchanged. Any fault on a load sets o_rdata = 0.
- Outside ACCESS, o_mem_en, o_mem_we, o_mem_addr and o_mem_wdata are all 0.
- Reset: state goes to IDLE immediately. All registered outputs go to 0 and the counter clears; an in-flight access is dropped (o_mem_en falls asynchronously). A late i_mem_ready seen after reset is ignored.
- i_req dropping in ACCESS is a protocol violation; the access still completes.

Test Plan:
- Load byte signed: addr 0x0000_0102, mem word 0x12_80_34_56, ready after 3 cycles -> o_mem_addr 0x040, o_mem_we 0000, o_rdata 0xFFFF_FF80, fault 00, o_done 4 cycles after accept, o_stall high throughout.
- Load half unsigned: addr 0x0000_0006, word 0xBEEF_1234, ready in cycle 1 -> o_rdata 0x0000_BEEF, o_done in cycle 2.
- Store byte: addr 0x0000_0003, wdata 0x0000_00AB -> o_mem_we 1000, o_mem_wdata 0xABAB_ABAB. Store half at addr 0x2, wdata 0x1234 -> o_mem_we 1100, o_mem_wdata 0x1234_1234.
- Faults:
  - Load word at addr 0x0000_0002 -> o_done in cycle 1, fault 01, o_rdata 0, o_mem_en never high.
  - Load type 010 -> fault 10.
  - Store type 010 at addr 0x1 -> fault 10, not 01 (priority).
- Timeout: TIMEOUT=4, ready held low -> o_mem_en high exactly 4 cycles, then o_done with fault 11. Ready on the 4th cycle -> fault 00.
- Reset mid-ACCESS, then back-to-back requests: o_mem_en falls immediately and no o_done is produced. After release, two consecutive loads with immediate ready -> o_done pulses 3 cycles apart, o_rdata updates per load.

Source files
------------

// File: rtl/mem_access_controller_if.sv
// Pipeline-request and data-memory bus bundle for mem_access_controller.
// Handshake: the pipeline holds i_req and every request field stable until it sees o_done;
// on the memory side o_mem_en holds the access steady until i_mem_ready completes it.
interface mem_access_controller_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  i_req;
  logic                  i_we;
  logic [2:0]            i_type;
  logic [31:0]           i_addr;
  logic [31:0]           i_wdata;
  logic                  o_stall;
  logic                  o_done;
  logic [31:0]           o_rdata;
  logic [1:0]            o_fault;
  logic                  o_mem_en;
  logic [3:0]            o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [31:0]           o_mem_wdata;
  logic [31:0]           i_mem_rdata;
  logic                  i_mem_ready;

  modport slave (
    input  i_req, i_we, i_type, i_addr, i_wdata, i_mem_rdata, i_mem_ready,
    output o_stall, o_done, o_rdata, o_fault, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req, i_we, i_type, i_addr, i_wdata, i_mem_rdata, i_mem_ready,
    input  o_stall, o_done, o_rdata, o_fault, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_access_controller.sv
// MEM-stage data-memory sequencer: validates a load/store, drives a word-addressed
// memory with byte lanes, waits for ready (bounded), and aligns/extends load data.
module mem_access_controller #(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  mem_access_controller_if.slave bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] F_OK      = 2'b00;
  localparam logic [1:0] F_MISALGN = 2'b01;
  localparam logic [1:0] F_TYPE    = 2'b10;
  localparam logic [1:0] F_TMO     = 2'b11;

  state_t                state, state_nxt;
  logic                  r_we;
  logic [2:0]            r_type;
  logic [1:0]            r_off;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]           r_wdata;
  logic [1:0]            r_fault;
  logic [7:0]            cnt;
  logic [31:0]           rdata_q;

  logic [1:0]            req_fault;
  logic                  tmo_hit;
  logic [31:0]           rd_shift;
  logic [31:0]           rd_ext;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^bus.i_addr[31:ADDR_WIDTH+2];

  // Type check shares one rule for loads and stores: size code 10 is never legal.
  always_comb begin
    req_fault = F_OK;
    if (bus.i_type[1:0] == 2'b10)
      req_fault = F_TYPE;
    else if ((bus.i_type[1:0] == 2'b01 && bus.i_addr[0]) ||
             (bus.i_type[1:0] == 2'b11 && bus.i_addr[1:0] != 2'b00))
      req_fault = F_MISALGN;
  end

  assign tmo_hit = (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    rd_shift = bus.i_mem_rdata >> {r_off, 3'b000};
    rd_ext   = rd_shift;
    case (r_type[1:0])
      2'b00:   rd_ext = r_type[2] ? {24'd0, rd_shift[7:0]}
                                  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = r_type[2] ? {16'd0, rd_shift[15:0]}
                                  : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.i_req) state_nxt = (req_fault != F_OK) ? S_DONE : S_ACCESS;
      S_ACCESS: if (bus.i_mem_ready || tmo_hit) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_we    <= 1'b0;
      r_type  <= 3'd0;
      r_off   <= 2'd0;
      r_waddr <= '0;
      r_wdata <= 32'd0;
      r_fault <= F_OK;
      cnt     <= 8'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_req) begin
            r_we    <= bus.i_we;
            r_type  <= bus.i_type;
            r_off   <= bus.i_addr[1:0];
            r_waddr <= bus.i_addr[ADDR_WIDTH+1:2];
            r_wdata <= bus.i_wdata;
            r_fault <= req_fault;
            cnt     <= 8'd0;
            if (req_fault != F_OK && !bus.i_we) rdata_q <= 32'd0;
          end
        end
        S_ACCESS: begin
          // Ready takes precedence over a timeout landing in the same cycle.
          if (bus.i_mem_ready) begin
            r_fault <= F_OK;
            if (!r_we) rdata_q <= rd_ext;
          end else if (tmo_hit) begin
            r_fault <= F_TMO;
            if (!r_we) rdata_q <= 32'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_mem_en    = 1'b0;
    bus.o_mem_we    = 4'b0000;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = 32'd0;
    if (state == S_ACCESS) begin
      bus.o_mem_en   = 1'b1;
      bus.o_mem_addr = r_waddr;
      if (r_we) begin
        case (r_type[1:0])
          2'b00: begin
            bus.o_mem_we    = 4'b0001 << r_off;
            bus.o_mem_wdata = {4{r_wdata[7:0]}};
          end
          2'b01: begin
            bus.o_mem_we    = 4'b0011 << r_off;
            bus.o_mem_wdata = {2{r_wdata[15:0]}};
          end
          default: begin
            bus.o_mem_we    = 4'b1111;
            bus.o_mem_wdata = r_wdata;
          end
        endcase
      end
    end
  end

  assign bus.o_done   = (state == S_DONE);
  assign bus.o_fault  = bus.o_done ? r_fault : F_OK;
  assign bus.o_stall  = bus.i_req & ~bus.o_done;
  assign bus.o_rdata  = rdata_q;
  assign o_dbg_state  = state;

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller: each task drives one scenario and
// checks hand-computed results inline.
module tb_mem_access_controller;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;
  longint cyc_abs = 0;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_controller_if #(.ADDR_WIDTH(AW)) bus ();

  mem_access_controller #(.ADDR_WIDTH(AW), .TIMEOUT(4)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  // Observations from the last run_req call
  int          obs_done_cyc;
  int          obs_en_cnt;
  logic        obs_stall_ok;
  logic        obs_stall_at_done;
  longint      obs_done_abs;
  logic [31:0] obs_rdata;
  logic [1:0]  obs_fault;
  logic [3:0]  obs_mem_we;
  logic [AW-1:0] obs_mem_addr;
  logic [31:0] obs_mem_wdata;

  // Presents one request in cycle 0 and raises ready in cycle ready_at (0 = never).
  task automatic run_req(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mem_word, input int ready_at);
    int cyc;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_we = we; bus.i_type = typ; bus.i_addr = addr;
    bus.i_wdata = wdata; bus.i_mem_rdata = mem_word;
    obs_done_cyc = -1; obs_en_cnt = 0; obs_stall_ok = 1'b1; obs_stall_at_done = 1'b1;
    obs_rdata = 32'hx; obs_fault = 2'bxx; obs_mem_we = 4'h0; obs_mem_addr = '0; obs_mem_wdata = 32'h0;
    obs_done_abs = 0;
    cyc = 0;
    while (cyc < 60) begin
      bus.i_mem_ready = (ready_at > 0 && cyc == ready_at);
      #1;
      if (bus.o_done) begin
        obs_done_cyc = cyc; obs_rdata = bus.o_rdata; obs_fault = bus.o_fault;
        obs_stall_at_done = bus.o_stall; obs_done_abs = cyc_abs;
        break;
      end
      if (!bus.o_stall) obs_stall_ok = 1'b0;
      if (bus.o_mem_en) begin
        obs_en_cnt++;
        obs_mem_we = bus.o_mem_we; obs_mem_addr = bus.o_mem_addr; obs_mem_wdata = bus.o_mem_wdata;
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_req = 1'b0;
    bus.i_mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    n_cmp++; if (bus.o_done !== 1'b0 || bus.o_fault !== 2'b00) begin n_bad++; $display("FAIL rst_done_fault: got %b/%b want 0/00", bus.o_done, bus.o_fault); end
    n_cmp++; if (bus.o_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus.o_rdata); end
    n_cmp++; if (bus.o_mem_en !== 1'b0 || bus.o_mem_we !== 4'h0 || bus.o_stall !== 1'b0) begin n_bad++; $display("FAIL rst_mem: en=%b we=%b stall=%b want 0", bus.o_mem_en, bus.o_mem_we, bus.o_stall); end
  endtask

  task automatic test_load_byte_signed();
    run_req(1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h1280_3456, 3);
    n_cmp++; if (obs_done_cyc !== 4) begin n_bad++; $display("FAIL lb_latency: got %0d want 4", obs_done_cyc); end
    n_cmp++; if (obs_rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rdata: got %h want ffffff80", obs_rdata); end
    n_cmp++; if (obs_fault !== 2'b00) begin n_bad++; $display("FAIL lb_fault: got %b want 00", obs_fault); end
    n_cmp++; if (obs_mem_addr !== 10'h040 || obs_mem_we !== 4'b0000) begin n_bad++; $display("FAIL lb_mem: addr %h we %b want 040/0000", obs_mem_addr, obs_mem_we); end
    n_cmp++; if (obs_en_cnt !== 3) begin n_bad++; $display("FAIL lb_en_cycles: got %0d want 3", obs_en_cnt); end
    n_cmp++; if (obs_stall_ok !== 1'b1 || obs_stall_at_done !== 1'b0) begin n_bad++; $display("FAIL lb_stall: held %b at_done %b want 1/0", obs_stall_ok, obs_stall_at_done); end
  endtask

  task automatic test_load_half_unsigned();
    run_req(1'b0, 3'b101, 32'h0000_0006, 32'h0, 32'hBEEF_1234, 1);
    n_cmp++; if (obs_done_cyc !== 2) begin n_bad++; $display("FAIL lhu_latency: got %0d want 2", obs_done_cyc); end
    n_cmp++; if (obs_rdata !== 32'h0000_BEEF) begin n_bad++; $display("FAIL lhu_rdata: got %h want 0000beef", obs_rdata); end
    n_cmp++; if (obs_mem_addr !== 10'h001) begin n_bad++; $display("FAIL lhu_addr: got %h want 001", obs_mem_addr); end
  endtask

  task automatic test_store();
    run_req(1'b1, 3'b000, 32'h0000_0003, 32'h0000_00AB, 32'h0, 1);
    n_cmp++; if (obs_mem_we !== 4'b1000 || obs_mem_wdata !== 32'hABAB_ABAB) begin n_bad++; $display("FAIL sb_lanes: we %b data %h want 1000/ababab ab", obs_mem_we, obs_mem_wdata); end
    n_cmp++; if (obs_fault !== 2'b00 || obs_done_cyc !== 2) begin n_bad++; $display("FAIL sb_done: fault %b cyc %0d want 00/2", obs_fault, obs_done_cyc); end
    n_cmp++; if (obs_rdata !== 32'h0000_BEEF) begin n_bad++; $display("FAIL sb_rdata_kept: got %h want 0000beef", obs_rdata); end
    run_req(1'b1, 3'b001, 32'h0000_0002, 32'h0000_1234, 32'h0, 1);
    n_cmp++; if (obs_mem_we !== 4'b1100 || obs_mem_wdata !== 32'h1234_1234) begin n_bad++; $display("FAIL sh_lanes: we %b data %h want 1100/12341234", obs_mem_we, obs_mem_wdata); end
    run_req(1'b1, 3'b111, 32'h0000_0004, 32'hCAFE_F00D, 32'h0, 2);
    n_cmp++; if (obs_mem_we !== 4'b1111 || obs_mem_wdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL sw_lanes: we %b data %h want 1111/cafef00d", obs_mem_we, obs_mem_wdata); end
  endtask

  task automatic test_faults();
    run_req(1'b1, 3'b010, 32'h0000_0001, 32'h0, 32'h0, 1);
    n_cmp++; if (obs_fault !== 2'b10) begin n_bad++; $display("FAIL st_type_prio: got %b want 10", obs_fault); end
    n_cmp++; if (obs_rdata !== 32'h0000_BEEF) begin n_bad++; $display("FAIL st_fault_rdata: got %h want 0000beef", obs_rdata); end
    run_req(1'b0, 3'b011, 32'h0000_0002, 32'h0, 32'h1111_1111, 1);
    n_cmp++; if (obs_done_cyc !== 1 || obs_fault !== 2'b01) begin n_bad++; $display("FAIL lw_misalign: cyc %0d fault %b want 1/01", obs_done_cyc, obs_fault); end
    n_cmp++; if (obs_rdata !== 32'h0 || obs_en_cnt !== 0) begin n_bad++; $display("FAIL lw_misalign_side: rdata %h en %0d want 0/0", obs_rdata, obs_en_cnt); end
    run_req(1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'h1111_1111, 1);
    n_cmp++; if (obs_fault !== 2'b10 || obs_en_cnt !== 0) begin n_bad++; $display("FAIL ld_type: fault %b en %0d want 10/0", obs_fault, obs_en_cnt); end
  endtask

  task automatic test_timeout();
    run_req(1'b0, 3'b011, 32'h0000_0008, 32'h0, 32'h5A5A_5A5A, 0);
    n_cmp++; if (obs_en_cnt !== 4 || obs_done_cyc !== 5) begin n_bad++; $display("FAIL tmo_cycles: en %0d done %0d want 4/5", obs_en_cnt, obs_done_cyc); end
    n_cmp++; if (obs_fault !== 2'b11 || obs_rdata !== 32'h0) begin n_bad++; $display("FAIL tmo_fault: fault %b rdata %h want 11/0", obs_fault, obs_rdata); end
    run_req(1'b0, 3'b011, 32'h0000_0008, 32'h0, 32'h5A5A_5A5A, 4);
    n_cmp++; if (obs_fault !== 2'b00 || obs_rdata !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL tmo_ready_wins: fault %b rdata %h want 00/5a5a5a5a", obs_fault, obs_rdata); end
    n_cmp++; if (obs_en_cnt !== 4 || obs_done_cyc !== 5) begin n_bad++; $display("FAIL tmo_ready_cycles: en %0d done %0d want 4/5", obs_en_cnt, obs_done_cyc); end
  endtask

  task automatic test_reset_mid_access();
    int seen_done;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_type = 3'b011; bus.i_addr = 32'h0000_0020;
    bus.i_mem_ready = 1'b0; bus.i_mem_rdata = 32'h7777_7777;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.o_mem_en !== 1'b1) begin n_bad++; $display("FAIL rma_en_before: got %b want 1", bus.o_mem_en); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_mem_en !== 1'b0 || dbg_state !== 2'd0) begin n_bad++; $display("FAIL rma_async: en %b state %0d want 0/0", bus.o_mem_en, dbg_state); end
    bus.i_req = 1'b0;
    @(negedge clk);
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) bus.i_mem_ready = 1'b0;
      if (bus.o_done || bus.o_mem_en) seen_done++;
    end
    n_cmp++; if (seen_done !== 0) begin n_bad++; $display("FAIL rma_no_done: got %0d active cycles want 0", seen_done); end
    n_cmp++; if (bus.o_rdata !== 32'h0) begin n_bad++; $display("FAIL rma_rdata: got %h want 0", bus.o_rdata); end
  endtask

  task automatic test_back_to_back();
    longint first_abs;
    run_req(1'b0, 3'b011, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1);
    first_abs = obs_done_abs;
    n_cmp++; if (obs_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL b2b_first: got %h want deadbeef", obs_rdata); end
    run_req(1'b0, 3'b100, 32'h0000_0011, 32'h0, 32'h0000_A500, 1);
    n_cmp++; if (obs_rdata !== 32'h0000_00A5) begin n_bad++; $display("FAIL b2b_second: got %h want 000000a5", obs_rdata); end
    n_cmp++; if (obs_done_abs - first_abs !== 64'd3) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 3", obs_done_abs - first_abs); end
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_type = 3'b000; bus.i_addr = 32'h0;
    bus.i_wdata = 32'h0; bus.i_mem_rdata = 32'h0; bus.i_mem_ready = 1'b0;
    test_reset();
    test_load_byte_signed();
    test_load_half_unsigned();
    test_store();
    test_faults();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
